// File: rtl/imem_load_scheduler.sv
// Arbitrates toggle-signalled instruction-memory loads from the host slave and the decoder
// onto a single AXI read engine, splitting each load into chunks of at most MAX_CHUNK beats.
module imem_load_scheduler #(
   parameter int AXI_ADDR_WIDTH = 42,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int MEM_REQ_W      = 16,
   parameter int MAX_CHUNK      = 256
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      slave_ld_req_in,
   input  logic [AXI_ADDR_WIDTH-1:0] slave_ld_addr,
   input  logic [MEM_REQ_W-1:0]      slave_ld_req_size,
   output logic                      slave_ld_done,
   input  logic                      decoder_ld_req_in,
   input  logic [AXI_ADDR_WIDTH-1:0] decoder_ld_addr,
   input  logic [MEM_REQ_W-1:0]      decoder_ld_req_size,
   output logic                      decoder_ld_done,
   output logic                      rd_req,
   input  logic                      rd_ready,
   output logic [AXI_ADDR_WIDTH-1:0] rd_addr,
   output logic [MEM_REQ_W-1:0]      rd_req_size,
   input  logic                      rd_done,
   output logic                      busy,
   output logic                      overflow
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [MEM_REQ_W-1:0]      CHUNK_MAX  = MEM_REQ_W'(MAX_CHUNK);
   localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);

   // Source index 0 is the slave, 1 is the decoder; last_grant uses the same encoding.
   logic [1:0]                req_tgl;
   logic [AXI_ADDR_WIDTH-1:0] req_addr  [2];
   logic [MEM_REQ_W-1:0]      req_size  [2];
   logic [1:0]                pend_vld;
   logic [AXI_ADDR_WIDTH-1:0] pend_addr [2];
   logic [MEM_REQ_W-1:0]      pend_size [2];
   logic [1:0]                src_drop;
   logic [1:0]                grant_now;

   logic [1:0]                state_q, state_d;
   logic                      owner_q, owner_d;
   logic                      last_grant_q, last_grant_d;
   logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [MEM_REQ_W-1:0]      remaining_q, remaining_d;
   logic [1:0]                done_tgl_q, done_tgl_d;
   logic                      overflow_q;
   logic [MEM_REQ_W-1:0]      chunk;
   logic [AXI_ADDR_WIDTH-1:0] chunk_bytes;
   logic                      gsel;

   assign req_tgl     = {decoder_ld_req_in, slave_ld_req_in};
   assign req_addr[0] = slave_ld_addr;
   assign req_addr[1] = decoder_ld_addr;
   assign req_size[0] = slave_ld_req_size;
   assign req_size[1] = decoder_ld_req_size;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic                      in_q;
         logic                      vld_q;
         logic [AXI_ADDR_WIDTH-1:0] addr_q;
         logic [MEM_REQ_W-1:0]      size_q;
         logic                      edge_det;
         logic                      active;
         logic                      accept;

         // An edge arriving while the entry is still full (even in its grant cycle) is lost.
         assign edge_det       = req_tgl[gi] ^ in_q;
         assign active         = (state_q != ST_IDLE) && (owner_q == 1'(gi));
         assign accept         = edge_det && !vld_q && !active;
         assign src_drop[gi]   = edge_det && !accept;
         assign pend_vld[gi]   = vld_q;
         assign pend_addr[gi]  = addr_q;
         assign pend_size[gi]  = size_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               in_q   <= 1'b0;
               vld_q  <= 1'b0;
               addr_q <= '0;
               size_q <= '0;
            end else begin
               in_q <= req_tgl[gi];
               if (accept) begin
                  vld_q  <= 1'b1;
                  addr_q <= req_addr[gi];
                  size_q <= req_size[gi];
               end else if (grant_now[gi]) begin
                  vld_q <= 1'b0;
               end
            end
         end
      end
   endgenerate

   assign chunk       = (remaining_q > CHUNK_MAX) ? CHUNK_MAX : remaining_q;
   assign chunk_bytes = {{(AXI_ADDR_WIDTH-MEM_REQ_W){1'b0}}, chunk} * BEAT_BYTES;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      cur_addr_d   = cur_addr_q;
      remaining_d  = remaining_q;
      done_tgl_d   = done_tgl_q;
      grant_now    = 2'b00;
      gsel         = (pend_vld == 2'b11) ? ~last_grant_q : pend_vld[1];
      case (state_q)
         ST_IDLE: begin
            if (|pend_vld) begin
               grant_now    = gsel ? 2'b10 : 2'b01;
               owner_d      = gsel;
               last_grant_d = gsel;
               cur_addr_d   = pend_addr[gsel];
               remaining_d  = pend_size[gsel];
               // Empty loads complete at the grant edge without touching the engine.
               if (pend_size[gsel] == '0) begin
                  done_tgl_d[gsel] = ~done_tgl_q[gsel];
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (rd_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (rd_done) begin
               remaining_d = remaining_q - chunk;
               cur_addr_d  = cur_addr_q + chunk_bytes;
               if (remaining_q == chunk) begin
                  done_tgl_d[owner_q] = ~done_tgl_q[owner_q];
                  state_d             = ST_IDLE;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cur_addr_q   <= '0;
         remaining_q  <= '0;
         done_tgl_q   <= 2'b00;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         cur_addr_q   <= cur_addr_d;
         remaining_q  <= remaining_d;
         done_tgl_q   <= done_tgl_d;
         overflow_q   <= overflow_q | (|src_drop);
      end
   end

   assign rd_req          = (state_q == ST_ISSUE);
   assign rd_addr         = cur_addr_q;
   assign rd_req_size     = chunk;
   assign busy            = (state_q != ST_IDLE) || (|pend_vld);
   assign overflow        = overflow_q;
   assign slave_ld_done   = done_tgl_q[0];
   assign decoder_ld_done = done_tgl_q[1];

endmodule

// File: tb/tb_imem_load_scheduler.sv
// Bench for imem_load_scheduler: a reactive read-engine model plus directed and randomized
// loads, each checked against a chunk list computed from the load address and size.
module tb_imem_load_scheduler;

   localparam int AW   = 42;
   localparam int W    = 16;
   localparam int MAXC = 256;
   localparam int BB   = 8;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [W-1:0]  s;
   } chunk_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          slave_ld_req_in, decoder_ld_req_in;
   logic [AW-1:0] slave_ld_addr, decoder_ld_addr;
   logic [W-1:0]  slave_ld_req_size, decoder_ld_req_size;
   logic          slave_ld_done, decoder_ld_done;
   logic          rd_req, rd_ready, rd_done, busy, overflow;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_req_size;

   int     n_cmp = 0;
   int     n_fail = 0;
   chunk_t acc_q[$];
   chunk_t exp_q[$];
   int     acc_rd = 0;
   int     stall_cfg = 0;
   int     ddly_cfg = -1;
   int     eng_st = 0;
   int     s_done_cnt = 0;
   int     d_done_cnt = 0;
   bit     model_last_dec = 1'b1;

   always #5 clk = ~clk;

   imem_load_scheduler dut (
      .clk                 (clk),
      .reset               (reset),
      .slave_ld_req_in     (slave_ld_req_in),
      .slave_ld_addr       (slave_ld_addr),
      .slave_ld_req_size   (slave_ld_req_size),
      .slave_ld_done       (slave_ld_done),
      .decoder_ld_req_in   (decoder_ld_req_in),
      .decoder_ld_addr     (decoder_ld_addr),
      .decoder_ld_req_size (decoder_ld_req_size),
      .decoder_ld_done     (decoder_ld_done),
      .rd_req              (rd_req),
      .rd_ready            (rd_ready),
      .rd_addr             (rd_addr),
      .rd_req_size         (rd_req_size),
      .rd_done             (rd_done),
      .busy                (busy),
      .overflow            (overflow)
   );

   // Read engine: optionally stalls rd_ready, logs each accepted chunk, then pulses rd_done.
   initial begin : engine
      int   stall_cnt;
      int   dwait;
      logic sd_prev, dd_prev;
      stall_cnt = 0; dwait = 0; sd_prev = 1'b0; dd_prev = 1'b0;
      rd_ready = 1'b0; rd_done = 1'b0;
      forever begin
         @(negedge clk); #1;
         rd_done = 1'b0;
         if (slave_ld_done !== sd_prev) s_done_cnt++;
         if (decoder_ld_done !== dd_prev) d_done_cnt++;
         sd_prev = slave_ld_done;
         dd_prev = decoder_ld_done;
         if (reset) begin
            eng_st = 0; rd_ready = 1'b0; stall_cnt = 0;
         end else if (eng_st == 0) begin
            if (rd_req === 1'b1) begin
               if (stall_cnt < stall_cfg) begin
                  stall_cnt++;
               end else begin
                  rd_ready = 1'b1;
                  acc_q.push_back('{a: rd_addr, s: rd_req_size});
                  eng_st = 1; stall_cnt = 0;
                  dwait = (ddly_cfg < 0) ? int'($urandom_range(0, 3)) : ddly_cfg;
               end
            end
         end else begin
            rd_ready = 1'b0;
            if (dwait == 0) begin
               rd_done = 1'b1; eng_st = 0;
            end else begin
               dwait--;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   // Reference: a load is the sequence of MAX_CHUNK-sized pieces with an 8-byte beat stride.
   task automatic model_load(input logic [AW-1:0] addr, input logic [W-1:0] size);
      logic [AW-1:0] a;
      int rem, c;
      a = addr; rem = int'(size);
      while (rem > 0) begin
         c = (rem > MAXC) ? MAXC : rem;
         exp_q.push_back('{a: a, s: W'(c)});
         a = a + AW'(c * BB);
         rem -= c;
      end
   endtask

   task automatic fire(input bit slv, input bit dec, input logic [AW-1:0] sa, input logic [W-1:0] ss,
                       input logic [AW-1:0] da, input logic [W-1:0] ds);
      if (slv) begin
         slave_ld_addr = sa; slave_ld_req_size = ss; slave_ld_req_in = ~slave_ld_req_in;
      end
      if (dec) begin
         decoder_ld_addr = da; decoder_ld_req_size = ds; decoder_ld_req_in = ~decoder_ld_req_in;
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      @(negedge clk);
      while ((busy !== 1'b0 || eng_st != 0) && k < budget) begin
         @(negedge clk); k++;
      end
      n_cmp++;
      if (k >= budget) begin
         n_fail++; $display("FAIL %s_timeout: busy=%0d after %0d cycles, want 0", tag, busy, k);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; slave_ld_req_in = 1'b0; decoder_ld_req_in = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req: got %0d want 0", rd_req); end
      n_cmp++; if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
      n_cmp++; if (rd_req_size !== '0) begin n_fail++; $display("FAIL reset_rd_size: got %0d want 0", rd_req_size); end
      n_cmp++; if (slave_ld_done !== 1'b0) begin n_fail++; $display("FAIL reset_slave_done: got %0d want 0", slave_ld_done); end
      n_cmp++; if (decoder_ld_done !== 1'b0) begin n_fail++; $display("FAIL reset_dec_done: got %0d want 0", decoder_ld_done); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d want 0", busy); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0d want 0", overflow); end
      reset = 1'b0;
      model_last_dec = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %0d want 0", busy); end
      acc_rd = acc_q.size(); exp_q.delete();
      $display("test_reset: done");
   endtask

   task automatic test_round_robin();
      int s0, d0;
      chunk_t got;
      s0 = s_done_cnt; d0 = d_done_cnt;
      for (int r = 0; r < 2; r++) begin
         fire(1, 1, AW'(42'h2000 + r * 42'h1000), W'(3 - r), AW'(42'h9000 + r * 42'h1000), W'(5 - 4 * r));
         model_load(AW'(42'h2000 + r * 42'h1000), W'(3 - r));
         model_load(AW'(42'h9000 + r * 42'h1000), W'(5 - 4 * r));
         wait_idle("rr", 200);
      end
      model_last_dec = 1'b1;
      n_cmp++; if (acc_q.size() - acc_rd != exp_q.size()) begin n_fail++; $display("FAIL rr_nchunks: got %0d want %0d", acc_q.size() - acc_rd, exp_q.size()); end
      foreach (exp_q[i]) begin
         got = (acc_rd + i < acc_q.size()) ? acc_q[acc_rd + i] : '0;
         n_cmp++;
         if (got !== exp_q[i]) begin n_fail++; $display("FAIL rr_order%0d: got %h/%0d want %h/%0d", i, got.a, got.s, exp_q[i].a, exp_q[i].s); end
         $display("round_robin: chunk %0d addr=%h size=%0d", i, got.a, got.s);
      end
      n_cmp++; if (s_done_cnt - s0 != 2 || d_done_cnt - d0 != 2) begin n_fail++; $display("FAIL rr_dones: got slave %0d dec %0d want 2 2", s_done_cnt - s0, d_done_cnt - d0); end
      acc_rd = acc_q.size(); exp_q.delete();
   endtask

   task automatic test_basic();
      int s0, d0;
      s0 = s_done_cnt; d0 = d_done_cnt;
      fire(1, 0, 42'h1000, 16'd4, '0, '0);
      @(negedge clk);
      n_cmp++; if (rd_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_t1: got rd_req=%0d busy=%0d want 0 1", rd_req, busy); end
      @(negedge clk);
      n_cmp++; if ({rd_req, rd_addr, rd_req_size} !== {1'b1, 42'h1000, 16'd4}) begin n_fail++; $display("FAIL basic_t2: got req=%0d addr=%h size=%0d want 1 1000 4", rd_req, rd_addr, rd_req_size); end
      wait_idle("basic", 200);
      model_last_dec = 1'b0;
      n_cmp++; if (s_done_cnt - s0 != 1 || d_done_cnt - d0 != 0) begin n_fail++; $display("FAIL basic_dones: got slave %0d dec %0d want 1 0", s_done_cnt - s0, d_done_cnt - d0); end
      n_cmp++; if (acc_q.size() - acc_rd != 1) begin n_fail++; $display("FAIL basic_nchunks: got %0d want 1", acc_q.size() - acc_rd); end
      $display("basic: slave load 0x1000/4 issued and completed");
      acc_rd = acc_q.size(); exp_q.delete();
   endtask

   task automatic test_multi_chunk();
      int s0, d0, k;
      logic [AW-1:0] base;
      chunk_t got;
      s0 = s_done_cnt; d0 = d_done_cnt;
      base = AW'({$urandom_range(0, 1023), $urandom()});
      exp_q.push_back('{a: base, s: 16'd256});
      exp_q.push_back('{a: base + 42'h800, s: 16'd256});
      exp_q.push_back('{a: base + 42'h1000, s: 16'd88});
      fire(0, 1, '0, '0, base, 16'd600);
      k = 0;
      while (acc_q.size() < acc_rd + 3 && k < 300) begin @(negedge clk); k++; end
      n_cmp++; if (k >= 300 || d_done_cnt - d0 != 0) begin n_fail++; $display("FAIL multi_early_done: got chunks=%0d dones=%0d want 3 0", acc_q.size() - acc_rd, d_done_cnt - d0); end
      wait_idle("multi", 300);
      model_last_dec = 1'b1;
      foreach (exp_q[i]) begin
         got = (acc_rd + i < acc_q.size()) ? acc_q[acc_rd + i] : '0;
         n_cmp++;
         if (got !== exp_q[i]) begin n_fail++; $display("FAIL multi_chunk%0d: got %h/%0d want %h/%0d", i, got.a, got.s, exp_q[i].a, exp_q[i].s); end
         $display("multi_chunk: chunk %0d addr=%h size=%0d", i, got.a, got.s);
      end
      n_cmp++; if (acc_q.size() - acc_rd != 3 || d_done_cnt - d0 != 1 || s_done_cnt != s0) begin n_fail++; $display("FAIL multi_totals: got chunks=%0d dec_dones=%0d want 3 1", acc_q.size() - acc_rd, d_done_cnt - d0); end
      acc_rd = acc_q.size(); exp_q.delete();
   endtask

   task automatic test_size_zero();
      logic old;
      old = slave_ld_done;
      fire(1, 0, 42'h5555, 16'd0, '0, '0);
      @(negedge clk);
      n_cmp++; if (slave_ld_done !== old) begin n_fail++; $display("FAIL zero_t1_done: got %0d want %0d", slave_ld_done, old); end
      @(negedge clk);
      n_cmp++; if (slave_ld_done !== ~old || rd_req !== 1'b0) begin n_fail++; $display("FAIL zero_t2: got done=%0d rd_req=%0d want %0d 0", slave_ld_done, rd_req, ~old); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %0d want 0", busy); end
      repeat (3) @(negedge clk);
      n_cmp++; if (acc_q.size() != acc_rd) begin n_fail++; $display("FAIL zero_no_rd: got %0d chunks want 0", acc_q.size() - acc_rd); end
      model_last_dec = 1'b0;
      $display("size_zero: done toggled without read request");
   endtask

   task automatic test_overflow();
      int s0, k;
      s0 = s_done_cnt;
      ddly_cfg = 8;
      fire(1, 0, 42'h4000, 16'd8, '0, '0);
      k = 0;
      while (rd_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      n_cmp++; if (rd_req !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_wait_state: got rd_req=%0d overflow=%0d want 0 0", rd_req, overflow); end
      fire(1, 0, 42'h5000, 16'd8, '0, '0);
      @(negedge clk);
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0d want 1", overflow); end
      wait_idle("ovf", 200);
      ddly_cfg = -1;
      model_last_dec = 1'b0;
      n_cmp++; if (s_done_cnt - s0 != 1) begin n_fail++; $display("FAIL ovf_dones: got %0d want 1", s_done_cnt - s0); end
      n_cmp++; if (acc_q.size() - acc_rd != 1 || acc_q[acc_q.size() - 1] !== {42'h4000, 16'd8}) begin n_fail++; $display("FAIL ovf_chunks: got %0d chunks want 1 at 4000/8", acc_q.size() - acc_rd); end
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0d want 1", overflow); end
      $display("overflow: second slave toggle dropped");
      acc_rd = acc_q.size(); exp_q.delete();
   endtask

   task automatic test_backpressure();
      int k;
      stall_cfg = 10;
      fire(1, 0, 42'h6000, 16'd300, '0, '0);
      model_load(42'h6000, 16'd300);
      k = 0;
      while (rd_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      for (int c = 0; c < 10; c++) begin
         n_cmp++;
         if ({rd_req, rd_addr, rd_req_size} !== {1'b1, 42'h6000, 16'd256}) begin n_fail++; $display("FAIL bp_hold%0d: got req=%0d addr=%h size=%0d want 1 6000 256", c, rd_req, rd_addr, rd_req_size); end
         @(negedge clk);
      end
      wait_idle("bp", 300);
      stall_cfg = 0;
      model_last_dec = 1'b0;
      n_cmp++; if (acc_q.size() - acc_rd != 2 || acc_q[acc_q.size() - 1] !== exp_q[1]) begin n_fail++; $display("FAIL bp_chunks: got %0d chunks want 2 ending 6800/44", acc_q.size() - acc_rd); end
      $display("backpressure: request held stable for 10 stalled cycles");
      acc_rd = acc_q.size(); exp_q.delete();
   endtask

   task automatic test_random();
      int mode, s0, d0, es, ed;
      logic [AW-1:0] sa, da;
      logic [W-1:0] ss, ds;
      chunk_t got;
      for (int it = 0; it < 20; it++) begin
         mode = (it == 0) ? 0 : int'($urandom_range(0, 2));
         sa = AW'({$urandom(), $urandom()});
         da = AW'({$urandom(), $urandom()});
         ss = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom_range(1, 700));
         ds = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom_range(1, 700));
         if (it == 0) begin sa = 42'h3FF_FFFF_FF00; ss = 16'd300; end
         stall_cfg = int'($urandom_range(0, 2));
         s0 = s_done_cnt; d0 = d_done_cnt;
         es = (mode != 1) ? 1 : 0; ed = (mode != 0) ? 1 : 0;
         fire(mode != 1, mode != 0, sa, ss, da, ds);
         if (mode == 0) begin
            model_load(sa, ss); model_last_dec = 1'b0;
         end else if (mode == 1) begin
            model_load(da, ds); model_last_dec = 1'b1;
         end else if (model_last_dec) begin
            model_load(sa, ss); model_load(da, ds); model_last_dec = 1'b1;
         end else begin
            model_load(da, ds); model_load(sa, ss); model_last_dec = 1'b0;
         end
         wait_idle("rnd", 1000);
         n_cmp++; if (acc_q.size() - acc_rd != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_nchunks: got %0d want %0d", it, acc_q.size() - acc_rd, exp_q.size()); end
         foreach (exp_q[i]) begin
            got = (acc_rd + i < acc_q.size()) ? acc_q[acc_rd + i] : '0;
            n_cmp++;
            if (got !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_chunk%0d: got %h/%0d want %h/%0d", it, i, got.a, got.s, exp_q[i].a, exp_q[i].s); end
         end
         n_cmp++; if (s_done_cnt - s0 != es || d_done_cnt - d0 != ed) begin n_fail++; $display("FAIL rnd%0d_dones: got %0d %0d want %0d %0d", it, s_done_cnt - s0, d_done_cnt - d0, es, ed); end
         $display("random %0d: mode=%0d slave %h/%0d dec %h/%0d chunks=%0d", it, mode, sa, ss, da, ds, exp_q.size());
         acc_rd = acc_q.size(); exp_q.delete();
      end
      stall_cfg = 0;
   endtask

   task automatic test_reset_mid_wait();
      int k;
      ddly_cfg = 20;
      fire(1, 0, 42'h7000, 16'd16, '0, '0);
      k = 0;
      while (rd_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b1 || rd_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre: got busy=%0d rd_req=%0d want 1 0", busy, rd_req); end
      reset = 1'b1; slave_ld_req_in = 1'b0; decoder_ld_req_in = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({rd_req, rd_addr, rd_req_size, slave_ld_done, decoder_ld_done, busy, overflow} !== '0) begin
         n_fail++; $display("FAIL rst_mid_outputs: got req=%0d addr=%h size=%0d sd=%0d dd=%0d busy=%0d ovf=%0d want all 0",
                            rd_req, rd_addr, rd_req_size, slave_ld_done, decoder_ld_done, busy, overflow);
      end
      reset = 1'b0;
      ddly_cfg = -1;
      model_last_dec = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || rd_req !== 1'b0 || slave_ld_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: got busy=%0d rd_req=%0d sd=%0d want 0 0 0", busy, rd_req, slave_ld_done); end
      $display("reset_mid_wait: load abandoned");
      acc_rd = acc_q.size(); exp_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      slave_ld_req_in = 1'b0; decoder_ld_req_in = 1'b0;
      slave_ld_addr = '0; decoder_ld_addr = '0;
      slave_ld_req_size = '0; decoder_ld_req_size = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_round_robin();
      test_basic();
      test_multi_chunk();
      test_size_zero();
      test_overflow();
      test_backpressure();
      test_random();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
